thco_mips_top: RTL and testbench

//  Self-contained top level of the 16-bit THCO-MIPS teaching CPU: single-cycle core plus internal

---
 rtl/thco_pkg.sv | 44 ++++
 rtl/thco_regfile.sv | 27 ++
 rtl/thco_mips_top.sv | 121 ++++++++++++
 tb/tb_thco_mips_top.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/thco_pkg.sv
// Shared definitions for the 16-bit THCO-MIPS core: field widths, opcodes, ALU ops.
package thco_pkg;
    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 3;

    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;

    localparam logic [4:0] OP_B      = 5'b00010;
    localparam logic [4:0] OP_BEQZ   = 5'b00100;
    localparam logic [4:0] OP_BNEZ   = 5'b00101;
    localparam logic [4:0] OP_SLL    = 5'b00110;
    localparam logic [4:0] OP_ADDIU3 = 5'b01000;
    localparam logic [4:0] OP_ADDIU  = 5'b01001;
    localparam logic [4:0] OP_BTEQZ  = 5'b01100;
    localparam logic [4:0] OP_LI     = 5'b01101;
    localparam logic [4:0] OP_MOVE   = 5'b01111;
    localparam logic [4:0] OP_LW     = 5'b10011;
    localparam logic [4:0] OP_SW     = 5'b11011;
    localparam logic [4:0] OP_RRR    = 5'b11100;
    localparam logic [4:0] OP_RR     = 5'b11101;

    localparam logic [4:0] FN_AND  = 5'b01100;
    localparam logic [4:0] FN_OR   = 5'b01101;
    localparam logic [4:0] FN_CMP  = 5'b01010;
    localparam logic [7:0] FN_MFPC = 8'b0100_0000;
    localparam logic [7:0] FN_JR   = 8'b0000_0000;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_PASSB
    } alu_op_e;

    function automatic logic [WORD_W-1:0] alu(alu_op_e op, logic [WORD_W-1:0] a,
                                              logic [WORD_W-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLL: return a << b[3:0];
            default: return b;
        endcase
    endfunction
endpackage

// File: rtl/thco_regfile.sv
// 8x16 general register file: two combinational read ports, one write port.
module thco_regfile
    import thco_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata1,
    output logic [WORD_W-1:0]     rdata2
);
    logic [WORD_W-1:0] regs [0:7];

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];
endmodule

// File: rtl/thco_mips_top.sv
// Single-cycle THCO-MIPS core with inline instruction ROM and data RAM.
module thco_mips_top
    import thco_pkg::*;
#(
    parameter string ROM_FILE  = "inst_rom.data",
    parameter int    ROM_DEPTH = 256,
    parameter int    RAM_DEPTH = 256
) (
    input  logic clk,
    input  logic rst
);
    localparam int ROM_AW = $clog2(ROM_DEPTH);
    localparam int RAM_AW = $clog2(RAM_DEPTH);

    logic [WORD_W-1:0] pc, pc_inc, inst, rd1, rd2, op_a, op_b, wdata, br_off, ram_rdata;
    logic [WORD_W-1:0] t_reg, sp_reg, ih_reg;
    logic [4:0]        op;
    logic [REG_ADDR_W-1:0] rx, ry, rz, rf_wa;
    logic [RAM_AW-1:0] ram_idx;
    logic              rf_we, ram_we, t_we, mem_to_reg, jump, br_taken;
    alu_op_e           alu_op;

    // The image named by ROM_FILE is placed into u_rom.mem by the simulation harness.
    if (1'b1) begin : u_rom
        logic [WORD_W-1:0] mem [ROM_DEPTH];
        assign inst = mem[pc[ROM_AW-1:0]];
    end

    assign op     = inst[15:11];
    assign rx     = inst[10:8];
    assign ry     = inst[7:5];
    assign rz     = inst[4:2];
    assign pc_inc = pc + 16'd1;

    thco_regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rx),
        .raddr2 (ry),
        .we     (rf_we),
        .waddr  (rf_wa),
        .wdata  (wdata),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    always_comb begin
        rf_we      = 1'b0;
        rf_wa      = rx;
        alu_op     = ALU_PASSB;
        op_a       = rd1;
        op_b       = rd2;
        mem_to_reg = 1'b0;
        ram_we     = 1'b0;
        t_we       = 1'b0;
        jump       = 1'b0;
        br_taken   = 1'b0;
        br_off     = {{8{inst[7]}}, inst[7:0]};
        case (op)
            OP_LI:     begin rf_we = 1'b1; op_b = {8'h00, inst[7:0]}; end
            OP_ADDIU:  begin rf_we = 1'b1; alu_op = ALU_ADD; op_b = {{8{inst[7]}}, inst[7:0]}; end
            OP_ADDIU3: if (!inst[4]) begin
                rf_we = 1'b1; rf_wa = ry; alu_op = ALU_ADD; op_b = {{12{inst[3]}}, inst[3:0]};
            end
            // funct 01 = ADDU, 11 = SUBU; anything with bit0 clear is not defined
            OP_RRR:    if (inst[0]) begin
                rf_we = 1'b1; rf_wa = rz; alu_op = inst[1] ? ALU_SUB : ALU_ADD;
            end
            OP_RR: begin
                if (inst[7:0] == FN_MFPC) begin
                    rf_we = 1'b1; op_b = pc_inc;
                end else if (inst[7:0] == FN_JR) begin
                    jump = 1'b1;
                end else begin
                    case (inst[4:0])
                        FN_AND:  begin rf_we = 1'b1; alu_op = ALU_AND; end
                        FN_OR:   begin rf_we = 1'b1; alu_op = ALU_OR; end
                        FN_CMP:  t_we = 1'b1;
                        default: ;
                    endcase
                end
            end
            OP_MOVE:   if (inst[4:0] == 5'd0) rf_we = 1'b1;
            // A zero shift field encodes a shift by 8.
            OP_SLL:    if (inst[1:0] == 2'd0) begin
                rf_we = 1'b1; alu_op = ALU_SLL; op_a = rd2;
                op_b = (rz == 3'd0) ? 16'd8 : {13'd0, rz};
            end
            OP_B:      begin br_taken = 1'b1; br_off = {{5{inst[10]}}, inst[10:0]}; end
            OP_BEQZ:   br_taken = (rd1 == '0);
            OP_BNEZ:   br_taken = (rd1 != '0);
            OP_BTEQZ:  if (rx == 3'd0) br_taken = (t_reg == '0);
            OP_LW:     begin rf_we = 1'b1; rf_wa = ry; mem_to_reg = 1'b1; end
            OP_SW:     ram_we = 1'b1;
            default:   ;
        endcase
    end

    assign ram_idx = RAM_AW'(rd1 + {{11{inst[4]}}, inst[4:0]});
    assign wdata   = mem_to_reg ? ram_rdata : alu(alu_op, op_a, op_b);

    if (1'b1) begin : u_ram
        logic [WORD_W-1:0] mem [RAM_DEPTH];
        always_ff @(posedge clk) begin
            if (rst == RstDisable && ram_we) mem[ram_idx] <= rd2;
        end
        assign ram_rdata = mem[ram_idx];
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc     <= '0;
            t_reg  <= '0;
            sp_reg <= '0;
            ih_reg <= '0;
        end else begin
            pc <= jump ? rd1 : (br_taken ? pc_inc + br_off : pc_inc);
            if (t_we) t_reg <= {15'd0, rd1 != rd2};
        end
    end
endmodule

// File: tb/tb_thco_mips_top.sv
// Bench for thco_mips_top: loads a program into the ROM and checks architectural state.
module tb_thco_mips_top;
    logic clk = 1'b0;
    logic rst = 1'b1;

    thco_mips_top dut (.clk(clk), .rst(rst));

    always #10 clk = ~clk;

    typedef enum int {K_PC, K_REG, K_T, K_RAM} kind_e;
    typedef struct {
        int          edges;
        kind_e       kind;
        int          idx;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic void add(int edges, kind_e kind, int idx, logic [15:0] exp, string name);
        vec_t v;
        v.edges = edges; v.kind = kind; v.idx = idx; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endfunction

    function automatic logic [15:0] sample(kind_e kind, int idx);
        case (kind)
            K_PC:    return dut.pc;
            K_REG:   return dut.u_regfile.regs[idx];
            K_T:     return dut.t_reg;
            default: return dut.u_ram.mem[idx];
        endcase
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic expect_now(string name, kind_e kind, int idx, logic [15:0] exp);
        logic [15:0] act, want;
        sb_q.push_back(exp);
        act  = sample(kind, idx);
        want = sb_q.pop_front();
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic check_val(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    initial begin
        logic [15:0] prog [0:30];
        prog = '{16'h6905, 16'h6A03, 16'hE14D, 16'hE153, 16'h4CFF, 16'h6840, 16'h6DAB,
                 16'hD8A2, 16'h98C2, 16'h0800, 16'hEF40, 16'h6900, 16'h2102, 16'h6EEE,
                 16'h6EEE, 16'h2902, 16'hE92A, 16'h6001, 16'h6EEE, 16'h6A81, 16'h3340,
                 16'hF800, 16'h1001, 16'h6EEE, 16'h43AF, 16'hEB4D, 16'hEBAC, 16'h7860,
                 16'hE94A, 16'h6001, 16'hEF00};
        for (int i = 0; i < 256; i++) dut.u_rom.mem[i] = 16'h0800;
        for (int i = 0; i < 31; i++) dut.u_rom.mem[i] = prog[i];

        add(1,  K_PC,  0,    16'd1,     "pc_seq1");
        add(1,  K_PC,  0,    16'd2,     "pc_seq2");
        add(1,  K_PC,  0,    16'd3,     "pc_seq3");
        add(0,  K_REG, 3,    16'h0008,  "addu_r3");
        add(1,  K_REG, 4,    16'h0002,  "subu_r4");
        add(1,  K_REG, 4,    16'h0001,  "addiu_r4");
        add(3,  K_PC,  0,    16'd8,     "pc_after_sw");
        add(0,  K_RAM, 'h42, 16'h00AB,  "sw_ram42");
        add(1,  K_REG, 6,    16'h00AB,  "lw_r6");
        add(2,  K_REG, 7,    16'd11,    "mfpc_r7");
        add(2,  K_PC,  0,    16'd15,    "beqz_taken");
        add(1,  K_PC,  0,    16'd16,    "bnez_fall");
        add(1,  K_T,   0,    16'd0,     "cmp_eq_t");
        add(1,  K_PC,  0,    16'd19,    "bteqz_taken");
        add(2,  K_REG, 3,    16'h8100,  "sll8_r3");
        add(1,  K_PC,  0,    16'd22,    "undef_nop_pc");
        add(0,  K_REG, 0,    16'h0040,  "undef_nop_r0");
        add(1,  K_PC,  0,    16'd24,    "b_taken");
        add(1,  K_REG, 5,    16'h80FF,  "addiu3_r5");
        add(1,  K_REG, 3,    16'h8181,  "or_r3");
        add(1,  K_REG, 3,    16'h8081,  "and_r3");
        add(1,  K_REG, 0,    16'h8081,  "move_r0");
        add(1,  K_T,   0,    16'd1,     "cmp_ne_t");
        add(1,  K_PC,  0,    16'd30,    "bteqz_fall");
        add(1,  K_PC,  0,    16'd11,    "jr_pc");
        add(0,  K_REG, 6,    16'h00AB,  "skipped_r6");
        add(32, K_PC,  0,    16'd11,    "loop_pc");

        // Power-on reset across one edge.
        rst = 1'b1;
        step(1);
        expect_now("rst_pc", K_PC, 0, 16'd0);
        for (int i = 0; i < 8; i++) expect_now($sformatf("rst_r%0d", i), K_REG, i, 16'd0);
        check_val("rst_sp", dut.sp_reg, 16'd0);
        check_val("rst_ih", dut.ih_reg, 16'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].edges);
            expect_now(vecs[i].name, vecs[i].kind, vecs[i].idx, vecs[i].exp);
        end

        // Reset in the middle of the loop: state clears, RAM survives.
        step(3);
        expect_now("mid_pc_before", K_PC, 0, 16'd16);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_now("mid_rst_pc", K_PC, 0, 16'd0);
        for (int i = 0; i < 8; i++) expect_now($sformatf("mid_rst_r%0d", i), K_REG, i, 16'd0);
        expect_now("mid_rst_t", K_T, 0, 16'd0);
        expect_now("mid_rst_ram42", K_RAM, 'h42, 16'h00AB);

        step(9);
        expect_now("rerun_lw_r6", K_REG, 6, 16'h00AB);
        step(2);
        expect_now("rerun_pc", K_PC, 0, 16'd11);
        step(80);
        expect_now("long_loop_pc", K_PC, 0, 16'd11);
        expect_now("long_loop_r7", K_REG, 7, 16'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
